// File: rtl/l2_cache_pkg.sv
// ---------------------------------------------------------------------------
// l2_cache_pkg
// Shared definitions for the write-back L2 cache:
//   - state_t     : controller states (IDLE, LOOKUP, WRITEBACK, FILL, RESP)
//   - calc_*_w()  : address-field and way-pointer widths derived from the
//                   cache parameters, so every file slices addresses the
//                   same way
// ---------------------------------------------------------------------------
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    RESP
  } state_t;

  // Byte-offset bits inside one word
  function automatic int calc_offset_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int data_width,
                                    input int num_sets);
    return addr_width - calc_index_w(num_sets) - calc_offset_w(data_width);
  endfunction

  // A direct-mapped cache still needs a one-bit way pointer to have a port
  function automatic int calc_way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/l2_victim_select.sv
// ---------------------------------------------------------------------------
// l2_victim_select
// Picks the way to replace in one set.
// Ports:
//   valid     in  NUM_WAYS  valid bits of the addressed set
//   rr        in  WAY_W     round-robin pointer of the addressed set
//   victim    out WAY_W     lowest invalid way, or rr when the set is full
//   all_valid out 1         every way of the set holds a line
// Purely combinational.
// ---------------------------------------------------------------------------
module l2_victim_select
  import l2_cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = calc_way_w(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr,
  output logic [WAY_W-1:0]    victim,
  output logic                all_valid
);

  // Scan from the top down so the lowest-numbered invalid way wins
  always_comb begin
    all_valid = &valid;
    victim    = rr;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l2_cache_wb.sv
// ---------------------------------------------------------------------------
// l2_cache_wb
// Set-associative, single-word-line, write-back / write-allocate L2 cache.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   l1_cache_addr/data_in   request byte address and write data
//   l1_cache_read/write     request strobes (write wins when both are high)
//   l1_cache_data_out       read data, valid while l1_cache_ready is high
//   l1_cache_ready          one-cycle completion pulse
//   l1_cache_hit            request was served from the cache
//   mem_addr/data_out       memory address and write-back data
//   mem_data_in             fill data
//   mem_read/write          fill / write-back strobes, held until mem_ready
//   mem_ready               completion of the outstanding memory request
// ---------------------------------------------------------------------------
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] l1_cache_addr,
  input  logic [DATA_WIDTH-1:0] l1_cache_data_in,
  input  logic                  l1_cache_read,
  input  logic                  l1_cache_write,
  output logic [DATA_WIDTH-1:0] l1_cache_data_out,
  output logic                  l1_cache_ready,
  output logic                  l1_cache_hit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready
);

  localparam int OFFSET_W = calc_offset_w(DATA_WIDTH);
  localparam int INDEX_W  = calc_index_w(NUM_SETS);
  localparam int TAG_W    = calc_tag_w(ADDR_WIDTH, DATA_WIDTH, NUM_SETS);
  localparam int WAY_W    = calc_way_w(NUM_WAYS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));

  state_t                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_write;
  logic [WAY_W-1:0]      victim_q;

  logic [TAG_W-1:0]      tag_mem  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty    [NUM_SETS];
  logic [WAY_W-1:0]      rr       [NUM_SETS];

  logic [INDEX_W-1:0]    req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim;
  logic                  all_valid;
  logic                  victim_dirty;
  logic [WAY_W-1:0]      rr_next;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic                  arr_we;
  logic [WAY_W-1:0]      arr_way;
  logic [DATA_WIDTH-1:0] arr_data;

  assign req_index    = req_addr[OFFSET_W +: INDEX_W];
  assign req_tag      = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign victim_dirty = valid[req_index][victim] & dirty[req_index][victim];
  assign rr_next      = (NUM_WAYS == 1) ? '0 : rr[req_index] + WAY_W'(1);
  // Rebuild the victim's line address from its stored tag and this set
  assign victim_addr  = (ADDR_WIDTH'(tag_mem[req_index][victim]) << (INDEX_W + OFFSET_W))
                      | (ADDR_WIDTH'(req_index) << OFFSET_W);

  l2_victim_select #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim (
    .valid     (valid[req_index]),
    .rr        (rr[req_index]),
    .victim    (victim),
    .all_valid (all_valid)
  );

  // Tag compare across every way of the latched set
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[req_index][w] && tag_mem[req_index][w] == req_tag) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Tag/data array write port: write hits, write-miss installs and fills.
  // Outside LOOKUP the target way is the victim captured during LOOKUP.
  always_comb begin
    arr_we   = 1'b0;
    arr_way  = victim_q;
    arr_data = req_data;
    case (state)
      LOOKUP: begin
        if (lookup_hit) begin
          arr_we  = req_write;
          arr_way = hit_way;
        end else if (req_write && !victim_dirty) begin
          arr_we  = 1'b1;
          arr_way = victim;
        end
      end
      WRITEBACK: arr_we = mem_ready & req_write;
      FILL: begin
        arr_we   = mem_ready;
        arr_data = mem_data_in;
      end
      default: ;
    endcase
  end

  // Tag and data storage carry no reset; valid bits guard their contents
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[req_index][arr_way]  <= req_tag;
      data_mem[req_index][arr_way] <= arr_data;
    end
  end

  // Controller: request capture, lookup, write-back, fill and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      req_addr          <= '0;
      req_data          <= '0;
      req_write         <= 1'b0;
      victim_q          <= '0;
      l1_cache_data_out <= '0;
      l1_cache_ready    <= 1'b0;
      l1_cache_hit      <= 1'b0;
      mem_addr          <= '0;
      mem_data_out      <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (l1_cache_read || l1_cache_write) begin
            req_addr  <= l1_cache_addr;
            req_data  <= l1_cache_data_in;
            req_write <= l1_cache_write;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          victim_q <= victim;
          if (lookup_hit) begin
            if (req_write) dirty[req_index][hit_way] <= 1'b1;
            else           l1_cache_data_out <= data_mem[req_index][hit_way];
            l1_cache_hit   <= 1'b1;
            l1_cache_ready <= 1'b1;
            state          <= RESP;
          end else begin
            if (all_valid) rr[req_index] <= rr_next;
            if (victim_dirty) begin
              mem_write    <= 1'b1;
              mem_addr     <= victim_addr;
              mem_data_out <= data_mem[req_index][victim];
              state        <= WRITEBACK;
            end else if (req_write) begin
              valid[req_index][victim] <= 1'b1;
              dirty[req_index][victim] <= 1'b1;
              l1_cache_hit   <= 1'b0;
              l1_cache_ready <= 1'b1;
              state          <= RESP;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= req_addr & LINE_MASK;
              state    <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            dirty[req_index][victim_q] <= 1'b0;
            if (req_write) begin
              // Later assignment wins: the freshly written word is dirty
              valid[req_index][victim_q] <= 1'b1;
              dirty[req_index][victim_q] <= 1'b1;
              l1_cache_hit   <= 1'b0;
              l1_cache_ready <= 1'b1;
              state          <= RESP;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= req_addr & LINE_MASK;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid[req_index][victim_q] <= 1'b1;
            dirty[req_index][victim_q] <= 1'b0;
            l1_cache_data_out <= mem_data_in;
            l1_cache_hit      <= 1'b0;
            l1_cache_ready    <= 1'b1;
            mem_read          <= 1'b0;
            state             <= RESP;
          end
        end
        RESP: begin
          l1_cache_ready <= 1'b0;
          l1_cache_hit   <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_wb.sv
// ---------------------------------------------------------------------------
// tb_l2_cache_wb
// Directed bench for l2_cache_wb with 4 sets x 2 ways (index = addr[3:2]).
// A behavioural memory answers mem_read/mem_write after a programmable
// latency; expected responses are queued when a request is driven and
// checked when l1_cache_ready pulses.
// ---------------------------------------------------------------------------
module tb_l2_cache_wb;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SETS    = 4;
  localparam int WAYS    = 2;
  localparam int MEM_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] l1_cache_addr = '0;
  logic [DW-1:0] l1_cache_data_in = '0;
  logic          l1_cache_read = 1'b0;
  logic          l1_cache_write = 1'b0;
  logic [DW-1:0] l1_cache_data_out;
  logic          l1_cache_ready;
  logic          l1_cache_hit;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in = '0;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  l2_cache_wb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SETS   (SETS),
    .NUM_WAYS   (WAYS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .l1_cache_addr     (l1_cache_addr),
    .l1_cache_data_in  (l1_cache_data_in),
    .l1_cache_read     (l1_cache_read),
    .l1_cache_write    (l1_cache_write),
    .l1_cache_data_out (l1_cache_data_out),
    .l1_cache_ready    (l1_cache_ready),
    .l1_cache_hit      (l1_cache_hit),
    .mem_addr          (mem_addr),
    .mem_data_out      (mem_data_out),
    .mem_data_in       (mem_data_in),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_ready         (mem_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic        hit;
    string       tag;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  exp_t        sb[$];
  txn_t        mem_log[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_latency = MEM_LAT;
  bit          mem_stall = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] exp_last = '0;
  logic        prev_ready = 1'b0;

  // Backing-store contents; untouched lines hold an address-derived pattern
  function automatic logic [31:0] backing(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0] ^ 16'h3C3C, a[15:0]};
  endfunction

  function automatic txn_t popLog();
    if (mem_log.size() == 0) return '1;
    return mem_log.pop_front();
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Queue the response the L1 side should see for this request
  task automatic pushExpect(input logic [31:0] addr, input logic [31:0] data,
                            input bit wr, input bit exp_hit, input string tag);
    exp_t        e;
    logic [31:0] line;
    line  = addr & ~32'h3;
    e.tag = tag;
    e.hit = exp_hit;
    if (wr) begin
      ref_mem[line] = data;
      e.data = exp_last;
    end else begin
      e.data   = ref_mem.exists(line) ? ref_mem[line] : backing(line);
      exp_last = e.data;
    end
    sb.push_back(e);
  endtask

  // Drive one request, hold it until ready, and check its latency in edges
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input bit rd, input bit wr, input bit exp_hit,
                               input int exp_lat, input string tag);
    int cycles;
    bit done;
    mem_log.delete();
    pushExpect(addr, data, wr, exp_hit, tag);
    @(negedge clk);
    l1_cache_addr    = addr;
    l1_cache_data_in = data;
    l1_cache_read    = rd;
    l1_cache_write   = wr;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (l1_cache_ready) done = 1'b1;
    end
    l1_cache_read  = 1'b0;
    l1_cache_write = 1'b0;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_latency"}, cycles, exp_lat);
    if (!done) sb.delete();
  endtask

  // Memory responder: counts unstalled cycles of a held strobe
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_cnt   = 0;
      end
      if (mem_read || mem_write) begin
        if (!mem_stall) mem_cnt++;
        if (!mem_stall && mem_cnt >= mem_latency) begin
          mem_ready = 1'b1;
          if (mem_write) begin
            mem_model[mem_addr] = mem_data_out;
            mem_log.push_back({1'b1, mem_addr, mem_data_out});
          end else begin
            mem_data_in = backing(mem_addr);
            mem_log.push_back({1'b0, mem_addr, mem_data_in});
          end
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ready = 1'b0;
    end else begin
      if (mem_read || mem_write)
        checkOutput("strobe_exclusive", mem_read & mem_write, 0);
      if (l1_cache_ready) begin
        checkOutput("ready_single_cycle", prev_ready, 0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("[TB] FAIL unexpected_ready: observed ready=1, expected no response pending");
        end else begin
          e = sb.pop_front();
          checkOutput({e.tag, "_hit"}, l1_cache_hit, e.hit);
          checkOutput({e.tag, "_data"}, l1_cache_data_out, e.data);
        end
      end
      prev_ready = l1_cache_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    mem_model[32'h10] = 32'hDEADBEEF;
    ref_mem = mem_model;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_l1_outputs", {l1_cache_ready, l1_cache_hit, l1_cache_data_out}, 0);
    checkOutput("rst_mem_outputs", {mem_read, mem_write, mem_addr, mem_data_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", {l1_cache_ready, mem_read, mem_write}, 0);

    // 1: cold read miss, then hit
    $display("[TB] step 1: read miss then hit at 0x10");
    applyStimulus(32'h10, 0, 1, 0, 0, 2 + MEM_LAT, "t1_miss");
    checkOutput("t1_log_n", mem_log.size(), 1);
    checkOutput("t1_log0", popLog(), {1'b0, 32'h10, 32'hDEADBEEF});
    applyStimulus(32'h10, 0, 1, 0, 1, 2, "t1_hit");
    checkOutput("t1_hit_log_n", mem_log.size(), 0);

    // 2: write hit, clean fill of way 1, dirty eviction of way 0
    $display("[TB] step 2: write hit, fill, dirty eviction in set 0");
    applyStimulus(32'h10, 32'h11111111, 0, 1, 1, 2, "t2_wr_hit");
    checkOutput("t2_wr_log_n", mem_log.size(), 0);
    applyStimulus(32'h50, 0, 1, 0, 0, 2 + MEM_LAT, "t2_rd50");
    checkOutput("t2_rd50_log0", popLog(), {1'b0, 32'h50, backing(32'h50)});
    applyStimulus(32'h53, 0, 1, 0, 1, 2, "t2_offset_hit");
    applyStimulus(32'h90, 0, 1, 0, 0, 2 + 2 * MEM_LAT, "t2_rd90");
    checkOutput("t2_rd90_log_n", mem_log.size(), 2);
    checkOutput("t2_wb_first", popLog(), {1'b1, 32'h10, 32'h11111111});
    checkOutput("t2_fill_second", popLog(), {1'b0, 32'h90, backing(32'h90)});

    // 3: write miss into an empty set allocates without memory traffic
    $display("[TB] step 3: write miss allocate in set 1");
    applyStimulus(32'h24, 32'hA5A5A5A5, 0, 1, 0, 2, "t3_wr_miss");
    checkOutput("t3_log_n", mem_log.size(), 0);
    applyStimulus(32'h24, 0, 1, 0, 1, 2, "t3_rd_hit");

    // 4: read and write together behave as a write
    $display("[TB] step 4: simultaneous read and write at 0x14");
    applyStimulus(32'h14, 32'h5, 1, 1, 0, 2, "t4_both");
    checkOutput("t4_log_n", mem_log.size(), 0);
    applyStimulus(32'h14, 0, 1, 0, 1, 2, "t4_rd_hit");

    // 5: long memory stall during a fill of set 2
    $display("[TB] step 5: fill stalled for 20 cycles");
    mem_log.delete();
    mem_stall = 1'b1;
    pushExpect(32'h08, 0, 0, 0, "t5_fill");
    @(negedge clk);
    l1_cache_addr = 32'h08;
    l1_cache_read = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t5_stall", {mem_read, l1_cache_ready, mem_addr}, {1'b1, 1'b0, 32'h08});
    end
    #1;
    mem_latency = 1;
    mem_stall   = 1'b0;
    waited = 0;
    while (!mem_ready && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("t5_mem_ready", mem_ready, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_ready_one_edge", l1_cache_ready, 1);
    l1_cache_read = 1'b0;
    mem_latency   = MEM_LAT;
    checkOutput("t5_log0", popLog(), {1'b0, 32'h08, backing(32'h08)});

    // 6: reset in the middle of a write-back
    $display("[TB] step 6: reset during write-back");
    @(negedge clk);
    mem_log.delete();
    mem_stall     = 1'b1;
    l1_cache_addr = 32'h34;
    l1_cache_read = 1'b1;
    waited = 0;
    while (!mem_write && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t6_wb_started", mem_write, 1);
    checkOutput("t6_wb_addr", mem_addr, 32'h24);
    checkOutput("t6_wb_data", mem_data_out, 32'hA5A5A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_drop", {mem_write, mem_read, l1_cache_ready}, 0);
    checkOutput("t6_rst_l1", {l1_cache_hit, l1_cache_data_out}, 0);
    l1_cache_read = 1'b0;
    repeat (2) @(negedge clk);
    ref_mem   = mem_model;
    exp_last  = '0;
    sb.delete();
    mem_stall = 1'b0;
    rst_n     = 1'b1;
    applyStimulus(32'h90, 0, 1, 0, 0, 2 + MEM_LAT, "t6_rd_after_rst");
    checkOutput("t6_log_n", mem_log.size(), 1);
    checkOutput("t6_refill", popLog(), {1'b0, 32'h90, backing(32'h90)});

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
- Parametrised set-associative L2 cache between the L1 cache and main memory.
- Single-word lines; write-back, write-allocate.
- Per-set dirty bits and a per-set round-robin victim pointer.
- On a miss it writes a dirty victim back before filling. Write misses allocate without fetching from memory.

Parameters:
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- NUM_SETS, 64, sets; power of 2, at least 2.
- NUM_WAYS, 4, ways per set; power of 2, at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- l1_cache_addr  in  ADDR_WIDTH  request byte address
- l1_cache_data_in  in  DATA_WIDTH  write data
- l1_cache_read  in  1  read request
- l1_cache_write  in  1  write request; has priority over read
- l1_cache_data_out  out  DATA_WIDTH  read data, valid while l1_cache_ready is high
- l1_cache_ready  out  1  one-cycle completion pulse
- l1_cache_hit  out  1  served from cache; qualified by l1_cache_ready
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data_out  out  DATA_WIDTH  write-back data
- mem_data_in  in  DATA_WIDTH  fill data
- mem_read  out  1  fill request
- mem_write  out  1  write-back request
- mem_ready  in  1  memory completion for the outstanding request

Behaviour:
- Address split:
  - OFFSET_W = clog2(DATA_WIDTH/8), INDEX_W = clog2(NUM_SETS), TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W.
  - index = addr[OFFSET_W+:INDEX_W]; tag = upper bits; offset bits are ignored.
  - All memory addresses are issued with the offset bits zeroed.
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - All valid, dirty and round-robin pointers are cleared.
  - Tag and data arrays are not reset.
  - A reset mid-operation abandons the operation immediately; mem_read and mem_write drop asynchronously.
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE:
  - If read or write is high, latch addr, data and op (write wins), then go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP, hit (valid and tag match in any way):
  - Read: data_out = stored word.
  - Write: update the word and set dirty.
  - Set hit = 1; go to RESP.
  - The round-robin pointer is not updated on a hit.
- LOOKUP, miss, victim selection:
  - Victim is the lowest-indexed invalid way.
  - If all ways are valid, the victim is way rr[index], and rr[index] increments modulo NUM_WAYS.
- LOOKUP, miss, next state:
  - Victim valid and dirty: go to WRITEBACK with mem_addr = {victim tag, index, 0} and mem_data_out = victim data.
  - Otherwise: read goes to FILL; write installs (tag, data, valid = 1, dirty = 1) and goes to RESP with hit = 0.
- WRITEBACK:
  - mem_write is held high with address and data stable until mem_ready is sampled high.
  - At that edge: mem_write = 0, victim dirty is cleared, then read goes to FILL and write installs as above and goes to RESP.
- FILL:
  - mem_read is held high with mem_addr = request address (offset zeroed) until mem_ready is sampled high.
  - At that edge: install (tag, mem_data_in, valid = 1, dirty = 0), data_out = mem_data_in, hit = 0, mem_read = 0, go to RESP.
- RESP:
  - l1_cache_ready is high for exactly this one cycle.
  - Unconditionally go to IDLE; ready and hit clear on exit.
  - The requester holds its request until ready and drops it at the edge ending RESP, so the next request is never double-accepted.
- Latency, counted from the accepting edge:
  - Hit: ready is high in the cycle after the second edge.
  - Clean miss: 2 edges + memory latency.
  - Dirty miss: 2 edges + two memory transactions.
- Register updates:
  - l1_cache_data_out is unchanged on writes.
  - mem_ready is ignored outside WRITEBACK and FILL.
  - Request inputs are ignored outside IDLE.
- Invariants:
  - mem_read and mem_write are never high together.
  - Memory strobes are only high in their own states.
  - A tag is never valid in two ways of one set.

Decomposition:
- Package l2_cache_pkg:
  - State enum (IDLE..RESP).
  - Functions deriving OFFSET_W, INDEX_W, TAG_W from the parameters.
- Sub-module l2_victim_select:
  - Inputs: per-set valid vector and rr pointer.
  - Outputs: victim way and all_valid flag.
  - Combinational; parametrised by NUM_WAYS.

Test Plan (NUM_SETS = 4, NUM_WAYS = 2, index = addr[3:2]):
1. Read 0x10 after reset:
   - mem_read with mem_addr = 0x10; memory returns 0xDEADBEEF after 3 cycles.
   - Expect a 1-cycle ready with hit = 0 and data_out = 0xDEADBEEF.
   - Re-reading 0x10 gives hit = 1 with a 2-edge latency and no mem_read.
2. Write 0x10 = 0x11111111 (hit, no memory traffic), then read 0x50, then read 0x90 (all set 0):
   - 0x50 fills way 1.
   - 0x90 evicts way 0: mem_write to addr 0x10 with data 0x11111111 completes before mem_read to 0x90.
3. Write 0x24 = 0xA5A5A5A5 to empty set 1:
   - No mem_read or mem_write; ready with hit = 0.
   - A read of 0x24 then hits and returns 0xA5A5A5A5.
4. l1_cache_read and l1_cache_write both high at address 0x14 with data 0x5 (0x14 not cached):
   - Treated as a write miss: no memory traffic, hit = 0.
   - A later read of 0x14 returns 0x5 with hit = 1.
5. mem_ready held low for 20 cycles during FILL:
   - mem_read stays high with mem_addr stable; ready stays low.
   - Completes one edge after mem_ready rises.
6. rst_n pulsed low while mem_write is high:
   - mem_write and ready drop immediately.
   - After release, a read of a previously cached address misses (mem_read issued).
